te_fanout_iso: RTL and testbench

Parametrised timing-engine fanout with per-sink isolation sequencing, the generalised successor of the fixed two-sink source-to-sink interface distribution. One source power domain drives `W`-bit timing-engine signals to `NCH` sink domains, each sink having an independent isolation request. Each channel runs its own clamp/settle/pass state machine and a saturating isolation-event counter. Sits at top level between the source-domain timing engine and the sink modules, at the power-domain boundary.

---
 rtl/te_fanout_iso.sv | 142 ++++++++++++++
 tb/tb_te_fanout_iso.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/te_fanout_iso.sv
// te_fanout_iso -- timing-engine fanout from one source power domain to NCH
// sink domains. Each sink channel has its own isolation sequencer:
//   ISO    : output clamped to CLAMP_VAL
//   SETTLE : still clamped, waiting SETTLE_CYC cycles after release
//   PASS   : registered source data flows through
// A channel leaves PASS on its own iso_req bit or on loss of source power.
// It also keeps a saturating count of PASS->ISO entries.
//
// Ports
//   ck          clock
//   arst        async active-low reset
//   src_data    [W]       timing-engine bundle from the source domain
//   src_pwr_ok            source domain powered; low isolates every channel
//   iso_req     [NCH]     per-channel isolation request
//   snk_data    [NCH*W]   channel i at [i*W +: W]
//   iso_ack     [NCH]     channel isolated or settling (flop based)
//   snk_live    [NCH]     channel in PASS (flop based)
//   iso_events  [NCH*8]   channel i at [i*8 +: 8], saturating PASS->ISO count

// Per-channel isolation sequencer and output gate.
module te_fanout_ch #(
    parameter int             W          = 2,
    parameter logic [W-1:0]   CLAMP_VAL  = '0,
    parameter int             SETTLE_CYC = 4
) (
    input  logic         ck,
    input  logic         arst,
    input  logic [W-1:0] data_q,
    input  logic         force_iso,
    output logic [W-1:0] snk_data,
    output logic         iso_ack,
    output logic         snk_live,
    output logic [7:0]   iso_events
);
    localparam int CW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        ST_ISO    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PASS   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      ev_q, ev_d;

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            state_q <= ST_ISO;
            cnt_q   <= '0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_d    = ev_q;
        case (state_q)
            ST_ISO: begin
                if (!force_iso) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                // An abort wins over completion; the partial count is dropped
                // and re-initialised on the next ISO exit.
                if (force_iso)
                    state_d = ST_ISO;
                else if (cnt_q == CW'(SETTLE_CYC - 1))
                    state_d = ST_PASS;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_PASS: begin
                if (force_iso) begin
                    state_d = ST_ISO;
                    if (ev_q != 8'hFF)
                        ev_d = ev_q + 8'd1;
                end
            end
            default: state_d = ST_ISO;
        endcase
    end

    // Gating also looks at force_iso directly so that the clamp takes effect in
    // the same cycle as the request, before the state flop catches up.
    assign snk_data   = (state_q == ST_PASS && !force_iso) ? data_q : CLAMP_VAL;
    assign iso_ack    = (state_q != ST_PASS);
    assign snk_live   = (state_q == ST_PASS);
    assign iso_events = ev_q;
endmodule

module te_fanout_iso #(
    parameter int             NCH        = 2,
    parameter int             W          = 2,
    parameter logic [W-1:0]   CLAMP_VAL  = '0,
    parameter int             SETTLE_CYC = 4
) (
    input  logic             ck,
    input  logic             arst,
    input  logic [W-1:0]     src_data,
    input  logic             src_pwr_ok,
    input  logic [NCH-1:0]   iso_req,
    output logic [NCH*W-1:0] snk_data,
    output logic [NCH-1:0]   iso_ack,
    output logic [NCH-1:0]   snk_live,
    output logic [NCH*8-1:0] iso_events
);
    logic [W-1:0]   data_q;
    logic [NCH-1:0] force_iso;

    // One capture register shared by every channel.
    always_ff @(posedge ck or negedge arst) begin
        if (!arst) data_q <= '0;
        else       data_q <= src_data;
    end

    assign force_iso = iso_req | {NCH{~src_pwr_ok}};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        te_fanout_ch #(
            .W          (W),
            .CLAMP_VAL  (CLAMP_VAL),
            .SETTLE_CYC (SETTLE_CYC)
        ) u_ch (
            .ck         (ck),
            .arst       (arst),
            .data_q     (data_q),
            .force_iso  (force_iso[i]),
            .snk_data   (snk_data[i*W +: W]),
            .iso_ack    (iso_ack[i]),
            .snk_live   (snk_live[i]),
            .iso_events (iso_events[i*8 +: 8])
        );
    end
endmodule

// File: tb/tb_te_fanout_iso.sv
module tb_te_fanout_iso;
    logic        ck = 1'b0;
    logic        arst;
    logic [1:0]  src_data;
    logic        src_pwr_ok;
    logic [1:0]  iso_req;
    logic [3:0]  snk_data;
    logic [1:0]  iso_ack;
    logic [1:0]  snk_live;
    logic [15:0] iso_events;

    int vecs = 0;
    int errs = 0;

    te_fanout_iso #(.NCH(2), .W(2), .CLAMP_VAL(2'b00), .SETTLE_CYC(4)) dut (
        .ck(ck), .arst(arst), .src_data(src_data), .src_pwr_ok(src_pwr_ok),
        .iso_req(iso_req), .snk_data(snk_data), .iso_ack(iso_ack),
        .snk_live(snk_live), .iso_events(iso_events)
    );

    always #5 ck = ~ck;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic test_reset;
        arst = 1'b0; src_data = 2'b11; iso_req = 2'b00; src_pwr_ok = 1'b1;
        #2;
        vecs++; if (snk_data !== 4'b0000) begin errs++; $display("FAIL rst_snk_data got %b exp 0000", snk_data); end
        vecs++; if (iso_ack !== 2'b11) begin errs++; $display("FAIL rst_iso_ack got %b exp 11", iso_ack); end
        vecs++; if (snk_live !== 2'b00) begin errs++; $display("FAIL rst_snk_live got %b exp 00", snk_live); end
        vecs++; if (iso_events !== 16'h0000) begin errs++; $display("FAIL rst_iso_events got %h exp 0000", iso_events); end
        step(2);
        vecs++; if (snk_data !== 4'b0000) begin errs++; $display("FAIL rst_hold_snk_data got %b exp 0000", snk_data); end
        arst = 1'b1;
        step(4);
        vecs++; if (snk_live !== 2'b00) begin errs++; $display("FAIL rel_live_4 got %b exp 00", snk_live); end
        vecs++; if (iso_ack !== 2'b11) begin errs++; $display("FAIL rel_ack_4 got %b exp 11", iso_ack); end
        step(1);
        vecs++; if (snk_live !== 2'b11) begin errs++; $display("FAIL rel_live_5 got %b exp 11", snk_live); end
        vecs++; if (iso_ack !== 2'b00) begin errs++; $display("FAIL rel_ack_5 got %b exp 00", iso_ack); end
        vecs++; if (snk_data !== 4'b1111) begin errs++; $display("FAIL rel_snk_data got %b exp 1111", snk_data); end
    endtask

    task automatic test_independence;
        src_data = 2'b10;
        vecs++; if (snk_data !== 4'b1111) begin errs++; $display("FAIL lat_before got %b exp 1111", snk_data); end
        step(1);
        vecs++; if (snk_data !== 4'b1010) begin errs++; $display("FAIL lat_after got %b exp 1010", snk_data); end
        iso_req = 2'b01;
        #1;
        vecs++; if (snk_data !== 4'b1000) begin errs++; $display("FAIL ind_clamp got %b exp 1000", snk_data); end
        vecs++; if (iso_ack !== 2'b00) begin errs++; $display("FAIL ind_ack_same got %b exp 00", iso_ack); end
        step(1);
        vecs++; if (iso_ack !== 2'b01) begin errs++; $display("FAIL ind_ack got %b exp 01", iso_ack); end
        vecs++; if (snk_live !== 2'b10) begin errs++; $display("FAIL ind_live got %b exp 10", snk_live); end
        vecs++; if (iso_events !== 16'h0001) begin errs++; $display("FAIL ind_events got %h exp 0001", iso_events); end
    endtask

    task automatic test_settle_abort;
        iso_req = 2'b00;
        step(3);                      // SETTLE cycles 1..3 on channel 0
        vecs++; if (iso_ack !== 2'b01) begin errs++; $display("FAIL abort_ack_settle got %b exp 01", iso_ack); end
        iso_req = 2'b01;
        step(1);
        vecs++; if (snk_live[0] !== 1'b0) begin errs++; $display("FAIL abort_live got %b exp 0", snk_live[0]); end
        vecs++; if (iso_ack !== 2'b01) begin errs++; $display("FAIL abort_ack got %b exp 01", iso_ack); end
        iso_req = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            vecs++; if (snk_live !== 2'b10) begin errs++; $display("FAIL abort_resettle_%0d got %b exp 10", k, snk_live); end
        end
        step(1);
        vecs++; if (snk_live !== 2'b11) begin errs++; $display("FAIL abort_pass got %b exp 11", snk_live); end
        vecs++; if (iso_events !== 16'h0001) begin errs++; $display("FAIL abort_events got %h exp 0001", iso_events); end
    endtask

    task automatic test_pwr_loss;
        vecs++; if (snk_data !== 4'b1010) begin errs++; $display("FAIL pwr_pre got %b exp 1010", snk_data); end
        src_pwr_ok = 1'b0;
        #1;
        vecs++; if (snk_data !== 4'b0000) begin errs++; $display("FAIL pwr_clamp got %b exp 0000", snk_data); end
        step(1);
        vecs++; if (iso_ack !== 2'b11) begin errs++; $display("FAIL pwr_ack got %b exp 11", iso_ack); end
        vecs++; if (iso_events !== 16'h0102) begin errs++; $display("FAIL pwr_events got %h exp 0102", iso_events); end
        src_pwr_ok = 1'b1;
        step(4);
        vecs++; if (snk_live !== 2'b00) begin errs++; $display("FAIL pwr_live_4 got %b exp 00", snk_live); end
        vecs++; if (snk_data !== 4'b0000) begin errs++; $display("FAIL pwr_data_4 got %b exp 0000", snk_data); end
        step(1);
        vecs++; if (snk_live !== 2'b11) begin errs++; $display("FAIL pwr_live_5 got %b exp 11", snk_live); end
        vecs++; if (snk_data !== 4'b1010) begin errs++; $display("FAIL pwr_data_5 got %b exp 1010", snk_data); end
        // Request falls while power drops: still forced, stays in ISO.
        iso_req = 2'b01;
        step(1);
        iso_req = 2'b00; src_pwr_ok = 1'b0;
        step(2);
        vecs++; if (iso_ack !== 2'b11) begin errs++; $display("FAIL simul_ack got %b exp 11", iso_ack); end
        vecs++; if (iso_events !== 16'h0203) begin errs++; $display("FAIL simul_events got %h exp 0203", iso_events); end
        src_pwr_ok = 1'b1;
        step(5);
        vecs++; if (snk_live !== 2'b11) begin errs++; $display("FAIL simul_live got %b exp 11", snk_live); end
    endtask

    task automatic test_saturation;
        // Channel 1 starts at 2; after k cycles it holds min(2+k, 255).
        for (int k = 1; k <= 300; k++) begin
            iso_req = 2'b10;
            step(1);
            iso_req = 2'b00;
            step(5);
            if (k == 252) begin
                vecs++; if (iso_events[15:8] !== 8'd254) begin errs++; $display("FAIL sat_254 got %0d exp 254", iso_events[15:8]); end
            end
            if (k == 253) begin
                vecs++; if (iso_events[15:8] !== 8'd255) begin errs++; $display("FAIL sat_255 got %0d exp 255", iso_events[15:8]); end
            end
        end
        vecs++; if (iso_events[15:8] !== 8'd255) begin errs++; $display("FAIL sat_final got %0d exp 255", iso_events[15:8]); end
        vecs++; if (iso_events[7:0] !== 8'd3) begin errs++; $display("FAIL sat_ch0 got %0d exp 3", iso_events[7:0]); end
        vecs++; if (snk_live !== 2'b11) begin errs++; $display("FAIL sat_live got %b exp 11", snk_live); end
    endtask

    task automatic test_reset_mid_pass;
        for (int k = 0; k < 4; k++) begin
            iso_req = 2'b01;
            step(1);
            iso_req = 2'b00;
            step(5);
        end
        vecs++; if (iso_events[7:0] !== 8'd7) begin errs++; $display("FAIL mid_events7 got %0d exp 7", iso_events[7:0]); end
        src_data = 2'b01;
        step(1);
        vecs++; if (snk_data !== 4'b0101) begin errs++; $display("FAIL mid_pre got %b exp 0101", snk_data); end
        #2;
        arst = 1'b0;                  // mid-cycle, no clock edge involved
        #1;
        vecs++; if (snk_data !== 4'b0000) begin errs++; $display("FAIL mid_snk_data got %b exp 0000", snk_data); end
        vecs++; if (iso_ack !== 2'b11) begin errs++; $display("FAIL mid_ack got %b exp 11", iso_ack); end
        vecs++; if (snk_live !== 2'b00) begin errs++; $display("FAIL mid_live got %b exp 00", snk_live); end
        vecs++; if (iso_events !== 16'h0000) begin errs++; $display("FAIL mid_events got %h exp 0000", iso_events); end
        step(1);
        arst = 1'b1;
        step(5);
        vecs++; if (snk_live !== 2'b11) begin errs++; $display("FAIL mid_rel_live got %b exp 11", snk_live); end
        vecs++; if (snk_data !== 4'b0101) begin errs++; $display("FAIL mid_rel_data got %b exp 0101", snk_data); end
    endtask

    initial begin
        test_reset;
        test_independence;
        test_settle_abort;
        test_pwr_loss;
        test_saturation;
        test_reset_mid_pass;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
